// File: rtl/conv_pkg.sv
// Shared definitions for the convolver pixel streamer: FSM state encoding,
// default geometry and derived constants, and small sizing helpers.
package conv_pkg;

   // Default geometry of the convolver front end
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_KERNEL_SIZE = 5;
   localparam int DEF_IMAGE_SIZE  = 28;
   localparam int DEF_ADDR_WIDTH  = 10;

   // Constants derived from the default geometry
   localparam int NUM_PIXELS = DEF_IMAGE_SIZE * DEF_IMAGE_SIZE;
   localparam int OUT_SIZE   = DEF_IMAGE_SIZE - DEF_KERNEL_SIZE + 1;

   // Cycles between the last memory read and the last window becoming valid:
   // memory latency, pixel register, window register
   localparam int PIPE_LAT = 3;

   // Streamer sequencing states
   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   // Pixel count of a square image
   function automatic int num_pixels(input int image_size);
      return image_size * image_size;
   endfunction

   // Edge length of the valid-convolution output map
   function automatic int out_size(input int image_size, input int kernel_size);
      return image_size - kernel_size + 1;
   endfunction

endpackage

// File: rtl/conv_raster_counter.sv
// Row/column raster position tracker for a square image. Advances one pixel
// per enabled cycle, wrapping the column into the next row, and flags when
// the current pixel completes a full KERNEL_SIZE x KERNEL_SIZE window.
module conv_raster_counter #(
   parameter int IMAGE_SIZE  = 28,
   parameter int KERNEL_SIZE = 5,
   parameter int CNT_W       = $clog2(IMAGE_SIZE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             advance,
   output logic [CNT_W-1:0] row,
   output logic [CNT_W-1:0] col,
   output logic             in_window
);

   localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(IMAGE_SIZE - 1);
   localparam logic [CNT_W-1:0] FIRST_WIN = CNT_W'(KERNEL_SIZE - 1);

   // Step the raster position; column wraps into the next row, row wraps at the image end
   always_ff @(posedge clk) begin
      if (!reset) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col == LAST_POS) begin
            col <= '0;
            row <= (row == LAST_POS) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // A window is complete once enough rows and columns have been seen
   assign in_window = (row >= FIRST_WIN) && (col >= FIRST_WIN);

endmodule

// File: rtl/conv_pixel_streamer.sv
// Transmit side of the convolver pixel-input interface. Pulses the weight
// strobe, reads one image in raster order from a 1-cycle-latency memory,
// drives one pixel per clock into the window bank and flags every cycle in
// which the bank's window sits on a valid convolution position.
// Optional busy-cycle performance counter: define CONV_STREAMER_PERF_CNT_EN.
module conv_pixel_streamer
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int OUT_W       = $clog2(IMAGE_SIZE - KERNEL_SIZE + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [ADDR_WIDTH-1:0]        base_addr,
   output logic                         mem_en,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic [DATA_WIDTH-1:0]        mem_rdata,
   output logic                         weight_load,
   output logic signed [DATA_WIDTH-1:0] pixel_out,
   output logic                         window_valid,
   output logic [OUT_W-1:0]             out_row,
   output logic [OUT_W-1:0]             out_col,
   output logic                         busy,
   output logic                         done,
   output logic [15:0]                  cycle_count
);

   localparam int N_PIX = num_pixels(IMAGE_SIZE);
   localparam int CNT_W = $clog2(IMAGE_SIZE);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N_PIX - 1);
   localparam logic [1:0]            LAST_DRAIN = 2'(PIPE_LAT - 1);
   localparam logic [CNT_W-1:0]      WIN_OFS    = CNT_W'(KERNEL_SIZE - 1);

   state_t                state;
   state_t                state_next;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] base_reg;
   logic [ADDR_WIDTH-1:0] pix_idx;
   logic [1:0]            drain_cnt;
   logic                  rd_valid;
   logic                  pix_valid;
   logic [CNT_W-1:0]      cur_row;
   logic [CNT_W-1:0]      cur_col;
   logic                  cur_in_window;
   logic                  win_hit;

   assign accept = (state == IDLE) && start;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state sequencing and state-decoded control outputs
   always_comb begin
      state_next  = state;
      weight_load = 1'b0;
      mem_en      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LOAD_W;
            end
         end
         LOAD_W: begin
            weight_load = 1'b1;
            busy        = 1'b1;
            state_next  = STREAM;
         end
         STREAM: begin
            mem_en = 1'b1;
            busy   = 1'b1;
            if (pix_idx == LAST_IDX) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_cnt == LAST_DRAIN) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Address is the captured base plus the read index, wrapping with the address width
   assign mem_addr = mem_en ? (base_reg + pix_idx) : '0;

   // Capture the base on start and step the read and drain counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         base_reg  <= '0;
         pix_idx   <= '0;
         drain_cnt <= '0;
      end else if (accept) begin
         base_reg  <= base_addr;
         pix_idx   <= '0;
         drain_cnt <= '0;
      end else begin
         if (state == STREAM) begin
            pix_idx <= pix_idx + 1'b1;
         end
         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
         end
      end
   end

   // Register read data into the pixel output, zero whenever no pixel is in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_valid  <= 1'b0;
         pix_valid <= 1'b0;
         pixel_out <= '0;
      end else begin
         rd_valid  <= mem_en;
         pix_valid <= rd_valid;
         pixel_out <= rd_valid ? $signed(mem_rdata) : '0;
      end
   end

   // Raster position of the pixel currently on pixel_out
   conv_raster_counter #(
      .IMAGE_SIZE  (IMAGE_SIZE),
      .KERNEL_SIZE (KERNEL_SIZE),
      .CNT_W       (CNT_W)
   ) u_raster (
      .clk       (clk),
      .reset     (reset),
      .clear     (accept),
      .advance   (pix_valid),
      .row       (cur_row),
      .col       (cur_col),
      .in_window (cur_in_window)
   );

   assign win_hit = pix_valid && cur_in_window;

   // Window flag and output position lag the pixel by one cycle to match the bank
   always_ff @(posedge clk) begin
      if (!reset) begin
         window_valid <= 1'b0;
         out_row      <= '0;
         out_col      <= '0;
      end else begin
         window_valid <= win_hit;
         out_row      <= win_hit ? OUT_W'(cur_row - WIN_OFS) : '0;
         out_col      <= win_hit ? OUT_W'(cur_col - WIN_OFS) : '0;
      end
   end

`ifdef CONV_STREAMER_PERF_CNT_EN
   // Count busy cycles of the current image, saturating, held until the next start
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_count <= '0;
      end else if (accept) begin
         cycle_count <= '0;
      end else if (busy && (cycle_count != 16'hFFFF)) begin
         cycle_count <= cycle_count + 16'd1;
      end
   end
`else
   assign cycle_count = '0;
`endif

endmodule
